polymul_recon: RTL and testbench

//  Inverse of the polynomial divider: rebuilds N = Q*D + R (mod Q_MOD) from quotient, divisor and remainder memories.

---
 rtl/polymul_recon.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_polymul_recon.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polymul_recon.sv
// Rebuilds N = Q*D + R (mod Q_MOD) with an output-stationary schoolbook MAC, one tap per cycle.
// Per coefficient: (taps + 4) cycles; no backpressure, memories are assumed always ready.
module polymul_recon #(
    parameter int Q_MOD    = 4591,
    parameter int COEF_W   = 13,
    parameter int ADDR_W   = 11,
    parameter int MAX_DEG  = 760,
    parameter int DEG_ADDR = 2047,
    parameter int ACC_W    = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] deg_n,
    output logic [ADDR_W-1:0] q_addr,
    input  logic [COEF_W-1:0] q_rdata,
    output logic [ADDR_W-1:0] d_addr,
    input  logic [COEF_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [COEF_W-1:0] r_rdata,
    output logic [ADDR_W-1:0] n_addr,
    output logic [COEF_W-1:0] n_wdata,
    output logic              n_we
);

    localparam int PROD_W = 2 * COEF_W;
    localparam logic [ADDR_W-1:0] DEG_A  = ADDR_W'(DEG_ADDR);
    localparam logic [11:0]       MAXD   = 12'(MAX_DEG);
    localparam logic [ACC_W-1:0]  QM_ACC = ACC_W'(Q_MOD);

    typedef enum logic [3:0] {
        S_IDLE, S_RDDEG, S_CAPDEG, S_ERR, S_MAC,
        S_DRAIN, S_REDUCE, S_WRITE, S_WDEG, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   deg_n_q, deg_n_d;
    logic [ADDR_W-1:0]   q_addr_q, q_addr_d;
    logic [ADDR_W-1:0]   d_addr_q, d_addr_d;
    logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
    logic [ADDR_W-1:0]   n_addr_q, n_addr_d;
    logic [COEF_W-1:0]   n_wdata_q, n_wdata_d;
    logic                n_we_q, n_we_d;
    logic [COEF_W-1:0]   dq_q, dq_d;
    logic [COEF_W-1:0]   dd_q, dd_d;
    logic [COEF_W-1:0]   dr_q, dr_d;
    logic [11:0]         s_q, s_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic                drain_q, drain_d;
    logic                tap_iss_q, tap_iss_d;
    logic                r_iss_q, r_iss_d;
    logic                d1_q, d1_d;
    logic                rcap_q, rcap_d;
    logic                p_vld_q, p_vld_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [ACC_W-1:0]    acc_q, acc_d;

    logic [COEF_W-1:0]   k13, i13, kn, lo_n, hi_c;
    logic                empty_n;
    logic [11:0]         s_cap;

    // Tap window for the current k and the next k, widened to degree width.
    always_comb begin
        k13     = COEF_W'(k_q);
        i13     = COEF_W'(i_q);
        kn      = k13 + 13'd1;
        lo_n    = (kn > dd_q) ? (kn - dd_q) : '0;
        hi_c    = (k13 < dq_q) ? k13 : dq_q;
        empty_n = kn > COEF_W'(s_q);
        s_cap   = 12'(q_rdata) + 12'(d_rdata);
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        deg_n_d   = deg_n_q;
        q_addr_d  = q_addr_q;
        d_addr_d  = d_addr_q;
        r_addr_d  = r_addr_q;
        n_addr_d  = n_addr_q;
        n_wdata_d = n_wdata_q;
        n_we_d    = 1'b0;
        dq_d      = dq_q;
        dd_d      = dd_q;
        dr_d      = dr_q;
        s_d       = s_q;
        k_d       = k_q;
        i_d       = i_q;
        drain_d   = drain_q;
        tap_iss_d = 1'b0;
        r_iss_d   = 1'b0;
        d1_d      = tap_iss_q;
        rcap_d    = r_iss_q;
        p_vld_d   = d1_q;
        prod_d    = prod_q;
        acc_d     = acc_q;

        // Read data lands one cycle after the address; the R word seeds the accumulator.
        if (d1_q) begin
            prod_d = PROD_W'(q_rdata) * PROD_W'(d_rdata);
        end
        if (rcap_q) begin
            acc_d = (k13 > dr_q) ? '0 : ACC_W'(r_rdata);
        end else if (p_vld_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RDDEG;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    q_addr_d = DEG_A;
                    d_addr_d = DEG_A;
                    r_addr_d = DEG_A;
                end
            end
            S_RDDEG: begin
                state_d = S_CAPDEG;
            end
            S_CAPDEG: begin
                dq_d = q_rdata;
                dd_d = d_rdata;
                dr_d = r_rdata;
                s_d  = s_cap;
                if (s_cap > MAXD) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    deg_n_d   = (COEF_W'(s_cap) >= r_rdata) ? ADDR_W'(s_cap) : ADDR_W'(r_rdata);
                    k_d       = '0;
                    i_d       = '0;
                    q_addr_d  = '0;
                    d_addr_d  = '0;
                    r_addr_d  = '0;
                    tap_iss_d = 1'b1;
                    r_iss_d   = 1'b1;
                    state_d   = S_MAC;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            S_MAC: begin
                if (i13 < hi_c) begin
                    i_d       = i_q + 1'b1;
                    q_addr_d  = i_q + 1'b1;
                    d_addr_d  = ADDR_W'(k13 - i13 - 13'd1);
                    tap_iss_d = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_REDUCE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_REDUCE: begin
                n_wdata_d = COEF_W'(acc_q % QM_ACC);
                n_addr_d  = k_q;
                n_we_d    = 1'b1;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                if (k_q == deg_n_q) begin
                    n_addr_d  = DEG_A;
                    n_wdata_d = COEF_W'(deg_n_q);
                    n_we_d    = 1'b1;
                    state_d   = S_WDEG;
                end else begin
                    k_d      = k_q + 1'b1;
                    r_addr_d = ADDR_W'(kn);
                    r_iss_d  = 1'b1;
                    drain_d  = 1'b0;
                    // Past degQ+degD there are no taps; only the R word is fetched.
                    if (empty_n) begin
                        state_d = S_DRAIN;
                    end else begin
                        i_d       = ADDR_W'(lo_n);
                        q_addr_d  = ADDR_W'(lo_n);
                        d_addr_d  = ADDR_W'(kn - lo_n);
                        tap_iss_d = 1'b1;
                        state_d   = S_MAC;
                    end
                end
            end
            S_WDEG: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            deg_n_q   <= '0;
            q_addr_q  <= '0;
            d_addr_q  <= '0;
            r_addr_q  <= '0;
            n_addr_q  <= '0;
            n_wdata_q <= '0;
            n_we_q    <= 1'b0;
            dq_q      <= '0;
            dd_q      <= '0;
            dr_q      <= '0;
            s_q       <= '0;
            k_q       <= '0;
            i_q       <= '0;
            drain_q   <= 1'b0;
            tap_iss_q <= 1'b0;
            r_iss_q   <= 1'b0;
            d1_q      <= 1'b0;
            rcap_q    <= 1'b0;
            p_vld_q   <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            deg_n_q   <= deg_n_d;
            q_addr_q  <= q_addr_d;
            d_addr_q  <= d_addr_d;
            r_addr_q  <= r_addr_d;
            n_addr_q  <= n_addr_d;
            n_wdata_q <= n_wdata_d;
            n_we_q    <= n_we_d;
            dq_q      <= dq_d;
            dd_q      <= dd_d;
            dr_q      <= dr_d;
            s_q       <= s_d;
            k_q       <= k_d;
            i_q       <= i_d;
            drain_q   <= drain_d;
            tap_iss_q <= tap_iss_d;
            r_iss_q   <= r_iss_d;
            d1_q      <= d1_d;
            rcap_q    <= rcap_d;
            p_vld_q   <= p_vld_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign deg_n   = deg_n_q;
    assign q_addr  = q_addr_q;
    assign d_addr  = d_addr_q;
    assign r_addr  = r_addr_q;
    assign n_addr  = n_addr_q;
    assign n_wdata = n_wdata_q;
    assign n_we    = n_we_q;

endmodule

// File: tb/tb_polymul_recon.sv
// Randomized bench for polymul_recon: memories modelled here, results checked against a direct convolution.
module tb_polymul_recon;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, err, n_we;
    logic [10:0] deg_n, q_addr, d_addr, r_addr, n_addr;
    logic [12:0] q_rdata, d_rdata, r_rdata, n_wdata;

    logic [12:0] qmem [2048];
    logic [12:0] dmem [2048];
    logic [12:0] rmem [2048];
    logic [12:0] nmem [2048];

    int n_tests = 0;
    int n_fail  = 0;
    int m_n [2048];
    int m_deg, m_cyc;
    bit m_err;

    polymul_recon dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .deg_n(deg_n), .q_addr(q_addr), .q_rdata(q_rdata), .d_addr(d_addr),
        .d_rdata(d_rdata), .r_addr(r_addr), .r_rdata(r_rdata), .n_addr(n_addr),
        .n_wdata(n_wdata), .n_we(n_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        q_rdata <= qmem[q_addr];
        d_rdata <= dmem[d_addr];
        r_rdata <= rmem[r_addr];
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Coefficient value < 0 means random; words above each degree are random filler.
    task automatic load(input int dq, input int dd, input int dr,
                        input int qv, input int dv, input int rv);
        for (int a = 0; a < 2047; a++) begin
            qmem[a] = (a <= dq && qv >= 0) ? 13'(qv) : 13'($urandom_range(4590));
            dmem[a] = (a <= dd && dv >= 0) ? 13'(dv) : 13'($urandom_range(4590));
            rmem[a] = (a <= dr && rv >= 0) ? 13'(rv) : 13'($urandom_range(4590));
        end
        qmem[2047] = 13'(dq);
        dmem[2047] = 13'(dd);
        rmem[2047] = 13'(dr);
    endtask

    // N[k] = R[k] + sum over i+j=k of Q[i]*D[j], reduced; cycle budget from tap counts.
    task automatic model();
        int dq = int'(qmem[2047]);
        int dd = int'(dmem[2047]);
        int dr = int'(rmem[2047]);
        int s  = (dq + dd) % 4096;
        m_err = (s > 760);
        m_deg = 0;
        m_cyc = 2;
        if (!m_err) begin
            m_deg = (s > dr) ? s : dr;
            m_cyc = 3;
            for (int k = 0; k <= m_deg; k++) begin
                longint v = (k <= dr) ? longint'(rmem[k]) : 0;
                int taps = 0;
                for (int i = 0; i <= dq; i++) begin
                    int j = k - i;
                    if (j >= 0 && j <= dd) begin
                        v += longint'(qmem[i]) * longint'(dmem[j]);
                        taps++;
                    end
                end
                m_n[k] = int'(v % 4591);
                m_cyc += taps + 4;
            end
        end
    endtask

    task automatic run_job(input bit extra_start);
        int cyc = 0;
        int wr_cnt = 0;
        int done_cnt = 0;
        bit got = 0;
        model();
        for (int a = 0; a < 2048; a++) nmem[a] = 13'h1FFF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < 60000 && !got) begin
            @(posedge clk);
            cyc++;
            #1;
            start = extra_start && (cyc == 5);
            if (n_we) begin
                nmem[n_addr] = n_wdata;
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                got = 1;
            end
        end
        chk("done_seen", got, 1);
        if (got) begin
            chk("cycles", cyc, m_cyc);
            chk("err", err, m_err);
            chk("busy_at_done", busy, 0);
            if (m_err) chk("err_latency_le4", (cyc <= 4), 1);
            else chk("deg_n", deg_n, m_deg);
            @(posedge clk);
            #1;
            if (n_we) wr_cnt++;
            if (done) done_cnt++;
            chk("done_cnt", done_cnt, 1);
            if (m_err) begin
                chk("wr_cnt", wr_cnt, 0);
            end else begin
                chk("wr_cnt", wr_cnt, m_deg + 2);
                chk("n_deg", nmem[2047], m_deg);
                for (int k = 0; k <= m_deg; k++)
                    chk($sformatf("n[%0d]", k), nmem[k], m_n[k]);
            end
        end
    endtask

    task automatic load_test1();
        load(0, 1, 0, 1, -1, 3);
        dmem[0] = 13'd2;
        dmem[1] = 13'd1;
    endtask

    task automatic wait_write(input int addr, output bit found);
        found = 0;
        for (int n = 0; n < 5000 && !found; n++) begin
            @(negedge clk);
            if (n_we && n_addr == 11'(addr)) found = 1;
        end
    endtask

    initial begin
        bit found;
        rst   = 1'b1;
        start = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_n_we", n_we, 0);
        chk("rst_deg_n", deg_n, 0);
        chk("rst_q_addr", q_addr, 0);
        chk("rst_n_addr", n_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        load_test1();
        run_job(0);
        chk("t1_n0", nmem[0], 5);
        chk("t1_n1", nmem[1], 1);

        load(0, 0, 0, 4590, 4590, 0);
        run_job(0);
        chk("t2_n0", nmem[0], 1);

        load(100, 100, 0, 4590, 4590, 0);
        run_job(0);
        chk("t3_n100", nmem[100], 101);
        chk("t3_n200", nmem[200], 1);

        load(760, 0, 0, 4590, 4590, 0);
        run_job(0);
        chk("max_deg_n", deg_n, 760);
        chk("max_n760", nmem[760], 1);

        load(500, 400, 0, -1, -1, -1);
        run_job(0);
        repeat (3) @(posedge clk);
        #1 chk("err_held", err, 1);

        load(380, 381, 0, -1, -1, -1);
        run_job(0);

        load(0, 0, 3, 0, -1, -1);
        for (int a = 0; a < 4; a++) rmem[a] = 13'(a + 1);
        run_job(0);
        chk("t6_n3", nmem[3], 4);
        chk("t6_err_cleared", err, 0);

        for (int t = 0; t < 6; t++) begin
            load($urandom_range(20), $urandom_range(20), $urandom_range(60), -1, -1, -1);
            run_job(0);
        end

        // Reset in the middle of k=10 (tap phase), then in the middle of a write.
        load(8, 8, 5, -1, -1, -1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_write(9, found);
        chk("found_w9", found, 1);
        @(posedge clk);
        #1 chk("busy_pre_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mac_busy", busy, 0);
        chk("rst_mac_n_we", n_we, 0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_write(3, found);
        chk("found_w3", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_wr_n_we", n_we, 0);
        chk("rst_wr_busy", busy, 0);
        chk("rst_wr_deg_n", deg_n, 0);
        @(negedge clk);
        rst = 1'b0;

        load_test1();
        run_job(1);
        chk("t5_n0", nmem[0], 5);
        chk("t5_n1", nmem[1], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
